// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and defaults for the ATM PIN verifier
// Purpose : FSM state enum, default PIN length / attempt limit, BCD digit type.
// Ports   : none (package).
package atm_pkg;

  localparam int DEF_PIN_DIGITS   = 4;
  localparam int DEF_MAX_ATTEMPTS = 3;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_GRANTED,
    S_LOCKED
  } state_t;

  function automatic logic is_bcd(input bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_pin_digit_buffer.sv
// rtl/atm_pin_digit_buffer.sv - BCD shift buffer holding the digits typed so far
// Purpose : shifts accepted keypad digits into the LS nibble and counts them.
// Ports   : clk, i_resetn (sync, active-low)
//           i_clear  - zero buffer and count (wins over i_push)
//           i_push   - offer i_digit; taken only if BCD and buffer not full
//           i_digit  - keypad value
//           o_buf    - buffered digits, first digit ends up in the MS nibble
//           o_count  - number of digits buffered
module atm_pin_digit_buffer
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = DEF_PIN_DIGITS
) (
  input  logic                    clk,
  input  logic                    i_resetn,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic [3:0]              i_digit,
  output logic [4*PIN_DIGITS-1:0] o_buf,
  output logic [2:0]              o_count
);

  localparam int BW = 4 * PIN_DIGITS;

  logic [BW-1:0] r_buf;
  logic [2:0]    r_count;
  logic          w_accept;

  assign w_accept = i_push && is_bcd(i_digit) && (r_count < 3'(PIN_DIGITS));

  always_ff @(posedge clk) begin
    if (!i_resetn || i_clear) begin
      r_buf   <= '0;
      r_count <= 3'd0;
    end else if (w_accept) begin
      r_buf   <= (r_buf << 4) | BW'(i_digit);
      r_count <= r_count + 3'd1;
    end
  end

  assign o_buf   = r_buf;
  assign o_count = r_count;

endmodule

// File: rtl/atm_pin_verifier.sv
// rtl/atm_pin_verifier.sv - PIN entry FSM with attempt limit, lockout and keypad timeout
// Purpose : collects a BCD PIN from the keypad, compares it with the card's PIN,
//           grants access or counts failed attempts up to lockout.
// Ports   : clk, reset (sync, active-low)
//           card_inserted, stored_pin (BCD, digit 0 in MS nibble)
//           digit_valid/digit, enter, clear - keypad strobes
//           pin_entered, pin_error (1-cycle pulse), card_locked,
//           attempts_left, digit_count
module atm_pin_verifier
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = DEF_PIN_DIGITS,
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    card_inserted,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic                    enter,
  input  logic                    clear,
  output logic                    pin_entered,
  output logic                    pin_error,
  output logic                    card_locked,
  output logic [1:0]              attempts_left,
  output logic [2:0]              digit_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  r_state;
  logic [4*PIN_DIGITS-1:0] r_pin;
  logic [TW-1:0]           r_idle_cnt;
  logic [1:0]              r_attempts;
  logic                    r_pin_entered;
  logic                    r_pin_error;
  logic                    r_card_locked;

  logic [4*PIN_DIGITS-1:0] w_buf;
  logic [2:0]              w_count;
  logic                    w_in_collect;
  logic                    w_strobe;
  logic                    w_timeout;
  logic                    w_full_enter;
  logic                    w_short_enter;
  logic                    w_check_fail;
  logic                    w_fail;
  logic                    w_buf_clear;
  logic                    w_buf_push;

  // Card removal is folded into w_in_collect so it overrides every keypad event.
  assign w_in_collect  = (r_state == S_COLLECT) && card_inserted;
  assign w_strobe      = digit_valid || enter || clear;
  assign w_timeout     = w_in_collect && !w_strobe &&
                         (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_full_enter  = w_in_collect && !clear && enter && (w_count == 3'(PIN_DIGITS));
  assign w_short_enter = w_in_collect && !clear && enter && (w_count != 3'(PIN_DIGITS));
  assign w_check_fail  = (r_state == S_CHECK) && card_inserted && (w_buf != r_pin);
  assign w_fail        = w_short_enter || w_timeout || w_check_fail;

  assign w_buf_clear   = (r_state == S_IDLE) || !card_inserted ||
                         (w_in_collect && clear) || w_fail;
  assign w_buf_push    = w_in_collect && !clear && !enter && digit_valid;

  atm_pin_digit_buffer #(
    .PIN_DIGITS(PIN_DIGITS)
  ) u_buf (
    .clk     (clk),
    .i_resetn(reset),
    .i_clear (w_buf_clear),
    .i_push  (w_buf_push),
    .i_digit (digit),
    .o_buf   (w_buf),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_pin         <= '0;
      r_idle_cnt    <= '0;
      r_attempts    <= 2'd0;
      r_pin_entered <= 1'b0;
      r_pin_error   <= 1'b0;
      r_card_locked <= 1'b0;
    end else begin
      r_pin_error <= 1'b0;
      if (r_state != S_IDLE && !card_inserted) begin
        r_state       <= S_IDLE;
        r_idle_cnt    <= '0;
        r_attempts    <= 2'd0;
        r_pin_entered <= 1'b0;
        r_card_locked <= 1'b0;
      end else if (w_fail) begin
        // Shared path for short enter, timeout and wrong PIN.
        r_pin_error <= 1'b1;
        r_idle_cnt  <= '0;
        if (r_attempts <= 2'd1) begin
          r_attempts    <= 2'd0;
          r_card_locked <= 1'b1;
          r_state       <= S_LOCKED;
        end else begin
          r_attempts <= r_attempts - 2'd1;
          r_state    <= S_COLLECT;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (card_inserted) begin
              r_pin      <= stored_pin;
              r_attempts <= 2'(MAX_ATTEMPTS);
              r_idle_cnt <= '0;
              r_state    <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            if (w_full_enter) begin
              r_idle_cnt <= '0;
              r_state    <= S_CHECK;
            end else if (w_strobe) begin
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + TW'(1);
            end
          end
          S_CHECK: begin
            // Mismatch was taken by the w_fail branch above.
            r_pin_entered <= 1'b1;
            r_state       <= S_GRANTED;
          end
          default: ;
        endcase
      end
    end
  end

  assign pin_entered   = r_pin_entered;
  assign pin_error     = r_pin_error;
  assign card_locked   = r_card_locked;
  assign attempts_left = r_attempts;
  assign digit_count   = w_count;

endmodule

// File: tb/tb_atm_pin_verifier.sv
// tb/tb_atm_pin_verifier.sv - table-driven and directed checks for atm_pin_verifier
module tb_atm_pin_verifier;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        card_inserted;
  logic [15:0] stored_pin;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic        pin_entered;
  logic        pin_error;
  logic        card_locked;
  logic [1:0]  attempts_left;
  logic [2:0]  digit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atm_pin_verifier #(
    .PIN_DIGITS(4),
    .MAX_ATTEMPTS(3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .card_inserted(card_inserted),
    .stored_pin   (stored_pin),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .enter        (enter),
    .clear        (clear),
    .pin_entered  (pin_entered),
    .pin_error    (pin_error),
    .card_locked  (card_locked),
    .attempts_left(attempts_left),
    .digit_count  (digit_count)
  );

  // expected = {pin_entered, pin_error, card_locked, attempts_left[1:0], digit_count[2:0]}
  typedef struct {
    logic       card;
    logic       dv;
    logic [3:0] d;
    logic       en;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] ex(input logic pe, input logic perr, input logic lk,
                                    input logic [1:0] att, input logic [2:0] cnt);
    return {pe, perr, lk, att, cnt};
  endfunction

  task automatic add(input logic card, input logic dv, input logic [3:0] d, input logic en,
                     input logic clr, input logic pe, input logic perr, input logic lk,
                     input logic [1:0] att, input logic [2:0] cnt);
    vec_t v;
    v.card = card; v.dv = dv; v.d = d; v.en = en; v.clr = clr;
    v.exp  = ex(pe, perr, lk, att, cnt);
    tbl.push_back(v);
  endtask

  // Drive at negedge, let one rising edge act, sample 1 time unit later.
  task automatic step(input logic card, input logic dv, input logic [3:0] d,
                      input logic en, input logic clr);
    @(negedge clk);
    card_inserted = card; digit_valid = dv; digit = d; enter = en; clear = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {pin_entered, pin_error, card_locked, attempts_left, digit_count};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (pe,perr,lk,att,cnt)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; card_inserted = 1'b0; stored_pin = 16'h1234;
    digit_valid = 1'b0; digit = 4'd0; enter = 1'b0; clear = 1'b0;

    // Reset state
    step(1, 1, 4'd3, 0, 0);
    step(1, 0, 4'd0, 1, 0);
    check("reset_state", outs(), ex(0, 0, 0, 2'd0, 3'd0));
    step(0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    check("idle_no_card", outs(), ex(0, 0, 0, 2'd0, 3'd0));

    // Correct PIN with invalid and overflow digits, grant latency, keypad ignored in GRANTED
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,4'hA,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,4,0,0, 0,0,0,3,4);
    add(1,1,5,0,0, 0,0,0,3,4);
    add(1,0,0,1,0, 0,0,0,3,4);
    add(1,0,0,0,0, 1,0,0,3,4);
    add(1,1,7,0,0, 1,0,0,3,4);
    add(1,0,0,1,0, 1,0,0,3,4);
    add(0,0,0,0,0, 0,0,0,0,0);
    // 9,9, clear, 1, A, 2,3,4, enter
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,9,0,0, 0,0,0,3,1);
    add(1,1,9,0,0, 0,0,0,3,2);
    add(1,0,0,0,1, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,4'hA,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,4,0,0, 0,0,0,3,4);
    add(1,0,0,1,0, 0,0,0,3,4);
    add(1,0,0,0,0, 1,0,0,3,4);
    add(0,0,0,0,0, 0,0,0,0,0);
    // Wrong PIN 1235 three times -> lockout
    add(1,0,0,0,0, 0,0,0,3,0);
    for (int r = 0; r < 3; r++) begin
      add(1,1,1,0,0, 0,0,0,2'(3-r),1);
      add(1,1,2,0,0, 0,0,0,2'(3-r),2);
      add(1,1,3,0,0, 0,0,0,2'(3-r),3);
      add(1,1,5,0,0, 0,0,0,2'(3-r),4);
      add(1,0,0,1,0, 0,0,0,2'(3-r),4);
      add(1,0,0,0,0, 0,1,(r == 2),2'(2-r),0);
    end
    add(1,0,0,0,0, 0,0,1,0,0);
    add(1,1,1,0,0, 0,0,1,0,0);
    add(1,0,0,1,0, 0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,0,0);
    // Same-cycle priority: clear beats enter and digit; enter beats digit
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,4,0,0, 0,0,0,3,4);
    add(1,1,9,1,1, 0,0,0,3,0);
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,4,1,0, 0,1,0,2,0);
    add(1,0,0,0,0, 0,0,0,2,0);
    add(0,0,0,0,0, 0,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].card, tbl[i].dv, tbl[i].d, tbl[i].en, tbl[i].clr);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Keypad timeout, then a short entry
    step(1, 0, 0, 0, 0);
    n = 0;
    while (!pin_error && n < TO + 100) begin
      step(1, 0, 0, 0, 0);
      n++;
    end
    check_int("timeout_cycles", n, TO - 1, TO + 1);
    check("timeout_fail", outs(), ex(0, 1, 0, 2'd2, 3'd0));
    step(1, 0, 0, 0, 0);
    check("timeout_pulse_end", outs(), ex(0, 0, 0, 2'd2, 3'd0));
    step(1, 1, 4'd1, 0, 0);
    step(1, 1, 4'd2, 0, 0);
    step(1, 0, 0, 1, 0);
    check("short_enter", outs(), ex(0, 1, 0, 2'd1, 3'd0));

    // Card pulled mid-entry, reinserted
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 4'd5, 0, 0);
    step(1, 1, 4'd6, 0, 0);
    check("two_digits", outs(), ex(0, 0, 0, 2'd3, 3'd2));
    step(0, 1, 4'd7, 1, 0);
    check("card_pulled", outs(), ex(0, 0, 0, 2'd0, 3'd0));
    step(1, 0, 0, 0, 0);
    check("reinserted", outs(), ex(0, 0, 0, 2'd3, 3'd0));

    // Lock via empty enters, then reset out of LOCKED
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("locked", outs(), ex(0, 1, 1, 2'd0, 3'd0));
    step(1, 0, 0, 1, 0);
    check("locked_no_underflow", outs(), ex(0, 0, 1, 2'd0, 3'd0));
    reset = 1'b0;
    step(1, 0, 0, 0, 0);
    check("reset_from_locked", outs(), ex(0, 0, 0, 2'd0, 3'd0));
    reset = 1'b1;
    step(1, 0, 0, 0, 0);
    check("after_reset_insert", outs(), ex(0, 0, 0, 2'd3, 3'd0));

    // Reset mid-entry
    step(1, 1, 4'd1, 0, 0);
    step(1, 1, 4'd2, 0, 0);
    reset = 1'b0;
    step(1, 1, 4'd3, 0, 0);
    check("reset_mid_entry", outs(), ex(0, 0, 0, 2'd0, 3'd0));
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
